m6809_fetch_dispatch: RTL and testbench
=======================================

Name: m6809_fetch_dispatch

Overview:
- Upstream instruction-fetch and dispatch sequencer for the 6809 core.
- Reads the opcode at PC from the byte-wide synchronous RAM, advances PC past it, and latches the opcode into IR.
- For register-move opcodes, pulses start to m6809_core_regmove and hands it the bus until it reports completion; that unit then fetches its own post-byte at the updated PC.
- Handles NOP internally, flags unsupported opcodes, and watchdogs the execution unit.

Parameters:
- WAIT_TIMEOUT, 64: cycles allowed in WAIT before a fault is declared (range 2..255).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reg_reset  input  1  asynchronous, active-high reset.
- run  input  1  level; 1 = keep fetching, 0 = stop at the next instruction boundary.
- addr  output  16  memory address; valid while bus_oe=1.
- data_rw_n  output  1  memory direction; this block only reads, so always 1.
- bus_oe  output  1  1 = this block owns addr/data_rw_n; 0 = execution unit owns the bus.
- din  input  8  memory read data; valid the cycle after addr is presented (synchronous RAM).
- pc_in  input  16  current PC from the external register file.
- pc_out  output  16  new PC value.
- pc_out_en  output  1  one-cycle write strobe for pc_out.
- ir_out  output  8  latched opcode, feeds regmove ir_in.
- start  output  1  one-cycle execute pulse to regmove.
- exec_done  input  1  one-cycle completion pulse from the execution unit.
- illegal  output  1  one-cycle pulse when an unsupported opcode is skipped.
- fault  output  1  sticky; set on WAIT timeout, cleared only by reg_reset.
- instr_count  output  CNT_W  count of retired instructions.
- busy  output  1  1 whenever state is not IDLE.

Behaviour:
- Reset: while reg_reset=1, outputs take these values immediately (asynchronous):
  - state=IDLE; addr=0; bus_oe=0; data_rw_n=1.
  - pc_out=0; pc_out_en=0; ir_out=0; start=0.
  - illegal=0; fault=0; instr_count=0; wait counter=0.
- Reset mid-operation aborts the instruction: no start pulse and no PC write may follow.
- IDLE: bus_oe=0. If run=1 and fault=0, go to FETCH next cycle.
- FETCH: addr=pc_in, bus_oe=1, data_rw_n=1. Unconditionally go to OPC.
- OPC:
  - bus_oe=1 and addr held.
  - Latch ir_out<=din.
  - pc_out=pc_in+1 (16-bit wrap: FFFF becomes 0000); pc_out_en=1 for exactly this cycle.
  - Go to DISPATCH.
- DISPATCH: bus_oe=0. Decode ir_out:
  - 34, 35, 36, 37, 1E, 1F: start=1 this cycle only; clear wait counter; go to WAIT.
  - 12 (NOP): instr_count+1; go to FETCH if run=1, else IDLE.
  - Anything else: illegal=1 for one cycle; instr_count unchanged; go to FETCH if run=1, else IDLE.
- WAIT:
  - bus_oe=0; the wait counter increments every cycle.
  - exec_done=1: instr_count+1; go to FETCH if run=1, else IDLE.
  - Counter reaches WAIT_TIMEOUT-1 with no exec_done: fault<=1, go to IDLE. While fault=1 the block stays in IDLE.
  - exec_done and timeout in the same cycle: exec_done wins, no fault.
- exec_done outside WAIT is ignored.
- run drop: only sampled at instruction boundaries (IDLE, end of DISPATCH for NOP/illegal, end of WAIT). An instruction already fetched always completes.
- Latency for a supported opcode: FETCH to start = 2 cycles. Minimum per instruction = 3 cycles + execution. NOP loop = 3 cycles/instruction.
- instr_count wraps modulo 2^CNT_W.
- start and pc_out_en are never high in the same cycle. bus_oe is never 1 in DISPATCH or WAIT.

Test Plan:
- NOP retire: RAM[00]=12, RAM[01]=12, pc_in starts 0000, run=1 → pc_out_en pulses with 0001 then 0002; instr_count reaches 2 within 6 cycles; start never asserts.
- Push dispatch: RAM[0010]=34, pc_in=0010 → addr=0010 in FETCH; ir_out=34 and pc_out=0011 in OPC; start high exactly 1 cycle in DISPATCH; bus_oe=0 until exec_done; instr_count+1 after exec_done.
- Illegal opcode: RAM[0020]=00 → illegal pulses 1 cycle; pc_out=0021; no start; next FETCH at 0021.
- Timeout: dispatch 1F with exec_done held 0, WAIT_TIMEOUT=8 → fault=1 after 8 WAIT cycles; block stays IDLE with run=1; only reg_reset clears fault.
- PC wrap: pc_in=FFFF, RAM byte = 12 → pc_out=0000.
- Reset mid-WAIT: assert reg_reset during WAIT → all outputs return to reset values the same cycle; after release with run=1, FETCH re-reads the current pc_in.

Source files
------------

// File: rtl/m6809_fetch_dispatch.sv
// m6809_fetch_dispatch: opcode fetch and dispatch sequencer.
// Fetches from synchronous RAM, hands register moves to regmove.
module m6809_fetch_dispatch #(
    parameter int WAIT_TIMEOUT = 64,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reg_reset,
    input  logic             run,
    output logic [15:0]      addr,
    output logic             data_rw_n,
    output logic             bus_oe,
    input  logic [7:0]       din,
    input  logic [15:0]      pc_in,
    output logic [15:0]      pc_out,
    output logic             pc_out_en,
    output logic [7:0]       ir_out,
    output logic             start,
    input  logic             exec_done,
    output logic             illegal,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_OPC,
        S_DISP,
        S_WAIT
    } state_t;

    localparam logic [7:0] W_LAST = 8'(WAIT_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [15:0]      r_addr;
    logic [15:0]      r_pc;
    logic [7:0]       r_ir;
    logic [7:0]       r_wcnt;
    logic             r_fault;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      w_pc_inc;
    logic             w_is_move;
    logic             w_is_nop;
    logic             w_timeout;
    logic             w_retire;
    logic             w_fault_set;

    assign w_pc_inc    = pc_in + 16'd1;
    assign w_is_nop    = (r_ir == 8'h12);
    assign w_timeout   = (r_wcnt == W_LAST);
    assign addr        = (r_state == S_FETCH) ? pc_in : r_addr;
    assign pc_out      = pc_out_en ? w_pc_inc : r_pc;
    assign data_rw_n   = 1'b1;
    assign ir_out      = r_ir;
    assign fault       = r_fault;
    assign instr_count = r_cnt;
    assign busy        = (r_state != S_IDLE);

    // Opcodes handed to the register-move execution unit
    always_comb begin
        w_is_move = 1'b0;
        case (r_ir)
            8'h34, 8'h35, 8'h36,
            8'h37, 8'h1E, 8'h1F: w_is_move = 1'b1;
            default:             w_is_move = 1'b0;
        endcase
    end

    // Next-state and per-state strobes
    always_comb begin
        w_next      = r_state;
        bus_oe      = 1'b0;
        pc_out_en   = 1'b0;
        start       = 1'b0;
        illegal     = 1'b0;
        w_retire    = 1'b0;
        w_fault_set = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (run && !r_fault) w_next = S_FETCH;
            end
            S_FETCH: begin
                bus_oe = 1'b1;
                w_next = S_OPC;
            end
            S_OPC: begin
                bus_oe    = 1'b1;
                pc_out_en = 1'b1;
                w_next    = S_DISP;
            end
            S_DISP: begin
                if (w_is_move) begin
                    start  = 1'b1;
                    w_next = S_WAIT;
                end else begin
                    w_retire = w_is_nop;
                    illegal  = !w_is_nop;
                    w_next   = run ? S_FETCH : S_IDLE;
                end
            end
            S_WAIT: begin
                if (exec_done) begin
                    w_retire = 1'b1;
                    w_next   = run ? S_FETCH : S_IDLE;
                end else if (w_timeout) begin
                    w_fault_set = 1'b1;
                    w_next      = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reg_reset) begin
        if (reg_reset) r_state <= S_IDLE;
        else           r_state <= w_next;
    end

    // Address hold, PC, IR, watchdog, fault and retire counter
    always_ff @(posedge clk or posedge reg_reset) begin
        if (reg_reset) begin
            r_addr  <= '0;
            r_pc    <= '0;
            r_ir    <= '0;
            r_wcnt  <= '0;
            r_fault <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (r_state == S_FETCH) r_addr <= pc_in;
            if (r_state == S_OPC) begin
                r_pc <= w_pc_inc;
                r_ir <= din;
            end
            if (start)                     r_wcnt <= '0;
            else if (r_state == S_WAIT)    r_wcnt <= r_wcnt + 8'd1;
            if (w_fault_set)               r_fault <= 1'b1;
            if (w_retire)                  r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_m6809_fetch_dispatch.sv
// tb_m6809_fetch_dispatch: randomized scoreboard bench.
// Model walks RAM bytes from PC to predict the event stream.
module tb_m6809_fetch_dispatch;

    localparam logic [1:0] EV_PCW   = 2'd0;
    localparam logic [1:0] EV_START = 2'd1;
    localparam logic [1:0] EV_ILL   = 2'd2;
    localparam logic [1:0] EV_RET   = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] a;
        logic [15:0] v;
    } ev_t;

    logic        clk = 1'b0;
    logic        reg_reset = 1'b0;
    logic        run = 1'b0;
    logic [15:0] addr;
    logic        data_rw_n;
    logic        bus_oe;
    logic [7:0]  din = 8'h00;
    logic [15:0] pc_in;
    logic [15:0] pc_out;
    logic        pc_out_en;
    logic [7:0]  ir_out;
    logic        start;
    logic        exec_done = 1'b0;
    logic        illegal;
    logic        fault;
    logic [15:0] instr_count;
    logic        busy;

    logic [7:0]  mem [0:65535];
    logic [15:0] tb_pc = 16'h0;
    logic        pc_set = 1'b0;
    logic [15:0] pc_set_val = 16'h0;
    logic        exec_en = 1'b1;
    logic [15:0] model_cnt = 16'h0;
    logic [15:0] prev_cnt = 16'h0;
    ev_t         q[$];
    int          vectors = 0;
    int          miscompares = 0;

    m6809_fetch_dispatch #(.WAIT_TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .reg_reset(reg_reset), .run(run),
        .addr(addr), .data_rw_n(data_rw_n), .bus_oe(bus_oe),
        .din(din), .pc_in(pc_in), .pc_out(pc_out),
        .pc_out_en(pc_out_en), .ir_out(ir_out), .start(start),
        .exec_done(exec_done), .illegal(illegal), .fault(fault),
        .instr_count(instr_count), .busy(busy)
    );

    always #5 clk = ~clk;

    assign pc_in = tb_pc;

    always @(posedge clk) din <= mem[addr];

    always @(posedge clk) begin
        if (pc_set)         tb_pc <= pc_set_val;
        else if (pc_out_en) tb_pc <= pc_out;
    end

    function automatic bit is_move(input logic [7:0] op);
        return op inside {8'h34, 8'h35, 8'h36, 8'h37, 8'h1E, 8'h1F};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] k, input logic [15:0] a,
                             input logic [15:0] v);
        ev_t e;
        vectors++;
        if (q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d a %h v %h expected none",
                     k, a, v);
        end else begin
            e = q.pop_front();
            if ({e.kind, e.a, e.v} !== {k, a, v}) begin
                miscompares++;
                $display("FAIL event: got kind %0d a %h v %h expected kind %0d a %h v %h",
                         k, a, v, e.kind, e.a, e.v);
            end
        end
    endtask

    // Reference model: walk k instructions from pc0 through RAM
    task automatic build(input logic [15:0] pc0, input int k);
        logic [15:0] p;
        logic [7:0]  op;
        p = pc0;
        for (int i = 0; i < k; i++) begin
            op = mem[p];
            q.push_back('{EV_PCW, p, p + 16'd1});
            p = p + 16'd1;
            if (is_move(op)) begin
                q.push_back('{EV_START, 16'h0, {8'h0, op}});
                model_cnt = model_cnt + 16'd1;
                q.push_back('{EV_RET, 16'h0, model_cnt});
            end else if (op == 8'h12) begin
                model_cnt = model_cnt + 16'd1;
                q.push_back('{EV_RET, 16'h0, model_cnt});
            end else begin
                q.push_back('{EV_ILL, 16'h0, {8'h0, op}});
            end
        end
    endtask

    function automatic logic [62:0] out_vec();
        return {addr, bus_oe, data_rw_n, pc_out, pc_out_en, ir_out,
                start, illegal, fault, instr_count, busy};
    endfunction

    localparam logic [62:0] RST_VEC =
        {16'h0, 1'b0, 1'b1, 16'h0, 1'b0, 8'h0,
         1'b0, 1'b0, 1'b0, 16'h0, 1'b0};

    task automatic set_pc(input logic [15:0] v);
        @(negedge clk);
        pc_set_val = v;
        pc_set = 1'b1;
        @(posedge clk);
        #1 pc_set = 1'b0;
    endtask

    task automatic run_phase(input logic [15:0] pc0, input int k);
        int n;
        int cyc;
        set_pc(pc0);
        build(pc0, k);
        run = 1'b1;
        n = 0;
        cyc = 0;
        while (n < k && cyc < k * 40) begin
            @(negedge clk);
            cyc++;
            if (pc_out_en) n++;
        end
        run = 1'b0;
        chk("phase_fetches", 64'(n), 64'(k));
        cyc = 0;
        @(negedge clk);
        while (busy && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("phase_idle", {63'h0, busy}, 64'h0);
        @(posedge clk);
        #1;
        chk("phase_queue_empty", 64'(q.size()), 64'h0);
        chk("phase_count", {48'h0, instr_count}, {48'h0, model_cnt});
        q.delete();
    endtask

    task automatic wait_start();
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (!start && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("start_seen", {63'h0, start}, 64'h1);
    endtask

    // Monitor: pops expected events whenever the DUT shows one
    initial begin
        forever begin
            @(negedge clk);
            if (reg_reset !== 1'b0) begin
                prev_cnt = instr_count;
            end else begin
                if (start)
                    chk("start_excl", {62'h0, bus_oe, pc_out_en}, 64'h0);
                if (pc_out_en) expect_ev(EV_PCW, addr, pc_out);
                if (start)     expect_ev(EV_START, 16'h0, {8'h0, ir_out});
                if (illegal)   expect_ev(EV_ILL, 16'h0, {8'h0, ir_out});
                if (instr_count != prev_cnt) begin
                    expect_ev(EV_RET, 16'h0, instr_count);
                    prev_cnt = instr_count;
                end
            end
        end
    end

    // Execution unit stand-in: completes 0..7 WAIT cycles after start
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (start && exec_en) begin
                d = $urandom_range(0, 7);
                @(posedge clk);
                repeat (d) @(posedge clk);
                #1 exec_done = 1'b1;
                @(posedge clk);
                #1 exec_done = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int r;
        int n;
        bit seen_busy;
        logic [7:0] moves [0:5];
        moves[0] = 8'h34; moves[1] = 8'h35; moves[2] = 8'h36;
        moves[3] = 8'h37; moves[4] = 8'h1E; moves[5] = 8'h1F;
        for (int i = 0; i < 65536; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      mem[i] = moves[$urandom_range(0, 5)];
            else if (r < 7) mem[i] = 8'h12;
            else            mem[i] = 8'($urandom);
        end

        #2 reg_reset = 1'b1;
        #1 chk("reset_outputs", {1'b0, out_vec()}, {1'b0, RST_VEC});
        repeat (3) @(posedge clk);
        #1 reg_reset = 1'b0;

        mem[16'h0000] = 8'h12;
        mem[16'h0001] = 8'h12;
        run_phase(16'h0000, 2);

        mem[16'h0010] = 8'h34;
        run_phase(16'h0010, 1);

        mem[16'h0020] = 8'h00;
        mem[16'h0021] = 8'h12;
        run_phase(16'h0020, 2);

        mem[16'hFFFF] = 8'h12;
        run_phase(16'hFFFF, 2);

        for (int p = 0; p < 12; p++)
            run_phase(16'($urandom), int'($urandom_range(3, 12)));

        // Watchdog timeout on a move that never completes
        exec_en = 1'b0;
        mem[16'h0040] = 8'h1F;
        set_pc(16'h0040);
        q.push_back('{EV_PCW, 16'h0040, 16'h0041});
        q.push_back('{EV_START, 16'h0, 16'h001F});
        run = 1'b1;
        wait_start();
        n = 0;
        while (!fault && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", 64'(n), 64'd9);
        seen_busy = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
        end
        chk("fault_stays_idle", {63'h0, seen_busy}, 64'h0);
        chk("fault_sticky", {63'h0, fault}, 64'h1);
        chk("timeout_queue", 64'(q.size()), 64'h0);
        run = 1'b0;
        @(posedge clk);
        #3 reg_reset = 1'b1;
        #1 chk("fault_reset", {1'b0, out_vec()}, {1'b0, RST_VEC});
        @(posedge clk);
        #1 reg_reset = 1'b0;
        model_cnt = 16'h0;
        q.delete();

        // Reset asserted while waiting on the execution unit
        mem[16'h0050] = 8'h35;
        set_pc(16'h0050);
        q.push_back('{EV_PCW, 16'h0050, 16'h0051});
        q.push_back('{EV_START, 16'h0, 16'h0035});
        run = 1'b1;
        wait_start();
        @(posedge clk);
        @(posedge clk);
        #3 reg_reset = 1'b1;
        #1 chk("midwait_reset", {1'b0, out_vec()}, {1'b0, RST_VEC});
        run = 1'b0;
        q.delete();
        model_cnt = 16'h0;
        @(posedge clk);
        #1 reg_reset = 1'b0;
        chk("midwait_queue", 64'(q.size()), 64'h0);
        chk("midwait_pc", {48'h0, tb_pc}, 64'h0051);
        exec_en = 1'b1;
        run_phase(tb_pc, 3);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
